// File: rtl/magphase_gain_mc.sv
// Multichannel magnitude/phase gain stage: per-channel signed gain, rounding right shift and
// saturation on each half of a packed {magnitude,phase} stream, with optional phase wrap.
module magphase_gain_mc #(
  parameter int WIDTH   = 16,
  parameter int GAIN_W  = 16,
  parameter int NUM_CH  = 4,
  parameter int SR_BASE = 192
) (
  input  logic               ce_clk,
  input  logic               ce_rst_n,
  input  logic               set_stb,
  input  logic [7:0]         set_addr,
  input  logic [31:0]        set_data,
  input  logic [2*WIDTH-1:0] i_tdata,
  input  logic               i_tlast,
  input  logic               i_tvalid,
  output logic               i_tready,
  output logic [2*WIDTH-1:0] o_tdata,
  output logic               o_tlast,
  output logic               o_tvalid,
  input  logic               o_tready,
  output logic [15:0]        clip_count_mag,
  output logic [15:0]        clip_count_phase
);

  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW   = WIDTH + GAIN_W;
  localparam int SH_W = $clog2(PW);
  localparam logic [7:0]          CTRL_ADDR = 8'(SR_BASE + 2*NUM_CH);
  localparam logic [GAIN_W-1:0]   GAIN_ONE  = GAIN_W'(1);
  localparam logic signed [PW:0]  SAT_HI    = {{(PW-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW:0]  SAT_LO    = {{(PW-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  // Settings: pending and active copies
  logic signed [GAIN_W-1:0] gm_pend_q [NUM_CH];
  logic signed [GAIN_W-1:0] gm_pend_d [NUM_CH];
  logic signed [GAIN_W-1:0] gp_pend_q [NUM_CH];
  logic signed [GAIN_W-1:0] gp_pend_d [NUM_CH];
  logic signed [GAIN_W-1:0] gm_act_q  [NUM_CH];
  logic signed [GAIN_W-1:0] gm_act_d  [NUM_CH];
  logic signed [GAIN_W-1:0] gp_act_q  [NUM_CH];
  logic signed [GAIN_W-1:0] gp_act_d  [NUM_CH];
  logic [SH_W-1:0] sh_pend_q, sh_pend_d, sh_act_q, sh_act_d;
  logic            wr_pend_q, wr_pend_d, wr_act_q, wr_act_d;

  // Packet tracking
  logic          in_pkt_q, in_pkt_d;
  logic [CW-1:0] idx_q, idx_d;

  // Stage 1
  logic                     s1_v_q, s1_v_d, s1_last_q, s1_last_d, s1_wr_q, s1_wr_d;
  logic signed [WIDTH-1:0]  s1_mag_q, s1_mag_d, s1_ph_q, s1_ph_d;
  logic signed [GAIN_W-1:0] s1_gm_q, s1_gm_d, s1_gp_q, s1_gp_d;
  logic [SH_W-1:0]          s1_sh_q, s1_sh_d;

  // Stage 2
  logic                 s2_v_q, s2_v_d, s2_last_q, s2_last_d, s2_wr_q, s2_wr_d;
  logic signed [PW-1:0] s2_pm_q, s2_pm_d, s2_pp_q, s2_pp_d;
  logic [SH_W-1:0]      s2_sh_q, s2_sh_d;

  // Stage 3 / outputs
  logic               ov_q, ov_d, ol_q, ol_d;
  logic [2*WIDTH-1:0] od_q, od_d;
  logic               s3_cm_q, s3_cm_d, s3_cp_q, s3_cp_d;
  logic [15:0]        cnt_mag_q, cnt_mag_d, cnt_ph_q, cnt_ph_d;

  logic en, accept, commit, wr_ctrl, clr;
  logic signed [PW:0] mag_r, ph_r;
  logic mag_clip, ph_clip;
  logic [WIDTH-1:0] mag_sat, ph_sat;
  logic unused_bits;

  assign unused_bits = ^set_data;

  function automatic logic signed [PW:0] rnd_shift(input logic signed [PW-1:0] p,
                                                   input logic [SH_W-1:0] sh);
    logic signed [PW:0] e;
    logic [PW:0] half;
    e = {p[PW-1], p};
    if (sh != '0) begin
      half = '0;
      half[sh - SH_W'(1)] = 1'b1;
      e = e + $signed(half);
      e = e >>> sh;
    end
    return e;
  endfunction

  always_comb begin
    en       = ~ov_q | o_tready;
    i_tready = en & ce_rst_n;
    accept   = i_tvalid & i_tready;
    commit   = ~in_pkt_q;
    wr_ctrl  = set_stb && (set_addr == CTRL_ADDR);
    clr      = wr_ctrl & set_data[31];
  end

  // Settings writes and shadow commit
  always_comb begin
    sh_pend_d = sh_pend_q;
    wr_pend_d = wr_pend_q;
    sh_act_d  = sh_act_q;
    wr_act_d  = wr_act_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      gm_pend_d[c] = gm_pend_q[c];
      gp_pend_d[c] = gp_pend_q[c];
      gm_act_d[c]  = gm_act_q[c];
      gp_act_d[c]  = gp_act_q[c];
      if (set_stb && set_addr == 8'(SR_BASE + 2*c))
        gm_pend_d[c] = set_data[GAIN_W-1:0];
      if (set_stb && set_addr == 8'(SR_BASE + 2*c + 1))
        gp_pend_d[c] = set_data[GAIN_W-1:0];
      if (commit) begin
        gm_act_d[c] = gm_pend_q[c];
        gp_act_d[c] = gp_pend_q[c];
      end
    end
    if (wr_ctrl) begin
      sh_pend_d = (int'(set_data[4:0]) > PW-1) ? SH_W'(PW-1) : SH_W'(set_data[4:0]);
      wr_pend_d = set_data[8];
    end
    if (commit) begin
      sh_act_d = sh_pend_q;
      wr_act_d = wr_pend_q;
    end
  end

  // Packet state and channel index; tlast reset beats the wrap
  always_comb begin
    in_pkt_d = in_pkt_q;
    idx_d    = idx_q;
    if (accept) begin
      in_pkt_d = ~i_tlast;
      if (i_tlast || idx_q == CW'(NUM_CH-1)) idx_d = '0;
      else                                   idx_d = idx_q + CW'(1);
    end
  end

  // Rounding, saturation and wrap on the stage-2 products
  always_comb begin
    mag_r    = rnd_shift(s2_pm_q, s2_sh_q);
    ph_r     = rnd_shift(s2_pp_q, s2_sh_q);
    mag_clip = (mag_r > SAT_HI) || (mag_r < SAT_LO);
    ph_clip  = ((ph_r > SAT_HI) || (ph_r < SAT_LO)) && !s2_wr_q;
    mag_sat  = mag_r[WIDTH-1:0];
    ph_sat   = ph_r[WIDTH-1:0];
    if (mag_clip) mag_sat = mag_r[PW] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    if (ph_clip)  ph_sat  = ph_r[PW]  ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  // Stall-all pipeline: every stage advances together on en
  always_comb begin
    s1_v_d = s1_v_q;   s1_last_d = s1_last_q; s1_wr_d = s1_wr_q;
    s1_mag_d = s1_mag_q; s1_ph_d = s1_ph_q;
    s1_gm_d = s1_gm_q; s1_gp_d = s1_gp_q;   s1_sh_d = s1_sh_q;
    s2_v_d = s2_v_q;   s2_last_d = s2_last_q; s2_wr_d = s2_wr_q;
    s2_pm_d = s2_pm_q; s2_pp_d = s2_pp_q;   s2_sh_d = s2_sh_q;
    ov_d = ov_q; ol_d = ol_q; od_d = od_q; s3_cm_d = s3_cm_q; s3_cp_d = s3_cp_q;
    if (en) begin
      s1_v_d    = accept;
      s1_last_d = i_tlast;
      s1_mag_d  = i_tdata[2*WIDTH-1:WIDTH];
      s1_ph_d   = i_tdata[WIDTH-1:0];
      s1_gm_d   = gm_act_q[idx_q];
      s1_gp_d   = gp_act_q[idx_q];
      s1_sh_d   = sh_act_q;
      s1_wr_d   = wr_act_q;
      s2_v_d    = s1_v_q;
      s2_last_d = s1_last_q;
      s2_pm_d   = s1_mag_q * s1_gm_q;
      s2_pp_d   = s1_ph_q * s1_gp_q;
      s2_sh_d   = s1_sh_q;
      s2_wr_d   = s1_wr_q;
      ov_d      = s2_v_q;
      ol_d      = s2_last_q;
      od_d      = {mag_sat, ph_sat};
      s3_cm_d   = mag_clip;
      s3_cp_d   = ph_clip;
    end
  end

  always_comb begin
    cnt_mag_d = cnt_mag_q;
    cnt_ph_d  = cnt_ph_q;
    if (clr) begin
      cnt_mag_d = '0;
      cnt_ph_d  = '0;
    end else if (ov_q && o_tready) begin
      if (s3_cm_q && cnt_mag_q != '1) cnt_mag_d = cnt_mag_q + 16'd1;
      if (s3_cp_q && cnt_ph_q != '1)  cnt_ph_d  = cnt_ph_q + 16'd1;
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        gm_pend_q[c] <= GAIN_ONE;
        gp_pend_q[c] <= GAIN_ONE;
        gm_act_q[c]  <= GAIN_ONE;
        gp_act_q[c]  <= GAIN_ONE;
      end
      sh_pend_q <= '0; wr_pend_q <= 1'b0; sh_act_q <= '0; wr_act_q <= 1'b0;
      in_pkt_q  <= 1'b0; idx_q <= '0;
      s1_v_q <= 1'b0; s1_last_q <= 1'b0; s1_wr_q <= 1'b0;
      s1_mag_q <= '0; s1_ph_q <= '0; s1_gm_q <= '0; s1_gp_q <= '0; s1_sh_q <= '0;
      s2_v_q <= 1'b0; s2_last_q <= 1'b0; s2_wr_q <= 1'b0;
      s2_pm_q <= '0; s2_pp_q <= '0; s2_sh_q <= '0;
      ov_q <= 1'b0; ol_q <= 1'b0; od_q <= '0; s3_cm_q <= 1'b0; s3_cp_q <= 1'b0;
      cnt_mag_q <= '0; cnt_ph_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        gm_pend_q[c] <= gm_pend_d[c];
        gp_pend_q[c] <= gp_pend_d[c];
        gm_act_q[c]  <= gm_act_d[c];
        gp_act_q[c]  <= gp_act_d[c];
      end
      sh_pend_q <= sh_pend_d; wr_pend_q <= wr_pend_d; sh_act_q <= sh_act_d; wr_act_q <= wr_act_d;
      in_pkt_q  <= in_pkt_d; idx_q <= idx_d;
      s1_v_q <= s1_v_d; s1_last_q <= s1_last_d; s1_wr_q <= s1_wr_d;
      s1_mag_q <= s1_mag_d; s1_ph_q <= s1_ph_d; s1_gm_q <= s1_gm_d; s1_gp_q <= s1_gp_d;
      s1_sh_q <= s1_sh_d;
      s2_v_q <= s2_v_d; s2_last_q <= s2_last_d; s2_wr_q <= s2_wr_d;
      s2_pm_q <= s2_pm_d; s2_pp_q <= s2_pp_d; s2_sh_q <= s2_sh_d;
      ov_q <= ov_d; ol_q <= ol_d; od_q <= od_d; s3_cm_q <= s3_cm_d; s3_cp_q <= s3_cp_d;
      cnt_mag_q <= cnt_mag_d; cnt_ph_q <= cnt_ph_d;
    end
  end

  always_comb begin
    o_tvalid         = ov_q;
    o_tlast          = ol_q;
    o_tdata          = od_q;
    clip_count_mag   = cnt_mag_q;
    clip_count_phase = cnt_ph_q;
  end

endmodule

// File: tb/tb_magphase_gain_mc.sv
// Directed bench for magphase_gain_mc: latency, gain/shift/rounding, saturation and wrap,
// channel interleave, shadowed gain updates, random handshake stream and mid-packet reset.
module tb_magphase_gain_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [31:0] i_tdata = '0;
  logic        i_tlast = 1'b0, i_tvalid = 1'b0, i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast, o_tvalid;
  logic        o_tready = 1'b1;
  logic [15:0] clip_count_mag, clip_count_phase;

  int unsigned n_pass = 0, n_total = 0;
  logic [32:0] outq[$];

  magphase_gain_mc #(.WIDTH(16), .GAIN_W(16), .NUM_CH(4), .SR_BASE(192)) dut (
    .ce_clk(clk), .ce_rst_n(rst_n),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .clip_count_mag(clip_count_mag), .clip_count_phase(clip_count_phase)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && o_tvalid && o_tready) outq.push_back({o_tlast, o_tdata});

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0; set_stb = 1'b0; o_tready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    outq.delete();
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] m, input logic [15:0] p, input logic last);
    bit ok = 0;
    i_tvalid = 1'b1; i_tdata = {m, p}; i_tlast = last;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (i_tready) ok = 1;
      @(posedge clk); #1;
    end
    i_tvalid = 1'b0; i_tlast = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    for (int k = 0; k < 400 && outq.size() < n; k++) tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (o_tvalid !== 1'b0) $display("FAIL rst_ovalid: got %b want 0", o_tvalid); else n_pass++;
    n_total++; if (o_tlast !== 1'b0) $display("FAIL rst_olast: got %b want 0", o_tlast); else n_pass++;
    n_total++; if (o_tdata !== 32'h0) $display("FAIL rst_odata: got %h want 0", o_tdata); else n_pass++;
    n_total++; if (i_tready !== 1'b1) $display("FAIL rst_itready: got %b want 1", i_tready); else n_pass++;
    n_total++; if (clip_count_mag !== 16'd0 || clip_count_phase !== 16'd0)
      $display("FAIL rst_counts: got %0d/%0d want 0/0", clip_count_mag, clip_count_phase); else n_pass++;
  endtask

  task automatic test_latency();
    i_tvalid = 1'b1; i_tdata = {16'd1000, 16'hF830}; i_tlast = 1'b1;
    @(negedge clk);
    n_total++; if (i_tready !== 1'b1) $display("FAIL lat_ready: got %b want 1", i_tready); else n_pass++;
    @(posedge clk); #1;
    i_tvalid = 1'b0; i_tlast = 1'b0;
    @(negedge clk);
    n_total++; if (o_tvalid !== 1'b0) $display("FAIL lat_c1: got %b want 0", o_tvalid); else n_pass++;
    @(negedge clk);
    n_total++; if (o_tvalid !== 1'b0) $display("FAIL lat_c2: got %b want 0", o_tvalid); else n_pass++;
    @(negedge clk);
    n_total++; if (o_tvalid !== 1'b1) $display("FAIL lat_c3: got %b want 1", o_tvalid); else n_pass++;
    n_total++; if ({o_tlast, o_tdata} !== {1'b1, 32'h03E8F830})
      $display("FAIL lat_data: got %b_%h want 1_03e8f830", o_tlast, o_tdata); else n_pass++;
    tick(); tick();
    n_total++; if (clip_count_mag !== 16'd0 || clip_count_phase !== 16'd0)
      $display("FAIL lat_counts: got %0d/%0d want 0/0", clip_count_mag, clip_count_phase); else n_pass++;
    outq.delete();
  endtask

  task automatic test_gain_shift();
    logic [32:0] got;
    write_reg(8'd192, 32'd768);
    write_reg(8'd200, 32'd8);
    tick(); tick();
    send_beat(16'd1000, 16'd512, 1'b1);
    wait_outs(1);
    got = (outq.size() > 0) ? outq.pop_front() : 'x;
    n_total++; if (got !== {1'b1, 16'd3000, 16'd2})
      $display("FAIL gain768: got %h want %h", got, {1'b1, 16'd3000, 16'd2}); else n_pass++;
    write_reg(8'd192, 32'd128);
    tick(); tick();
    send_beat(16'd1, 16'hFE80, 1'b1);
    send_beat(16'hFFFF, 16'd0, 1'b1);
    wait_outs(2);
    got = (outq.size() > 0) ? outq.pop_front() : 'x;
    n_total++; if (got !== {1'b1, 16'd1, 16'hFFFF})
      $display("FAIL round_pos: got %h want %h", got, {1'b1, 16'd1, 16'hFFFF}); else n_pass++;
    got = (outq.size() > 0) ? outq.pop_front() : 'x;
    n_total++; if (got !== {1'b1, 32'h0})
      $display("FAIL round_neg: got %h want %h", got, {1'b1, 32'h0}); else n_pass++;
  endtask

  task automatic test_saturate();
    logic [32:0] got;
    write_reg(8'd192, 32'd2);
    write_reg(8'd193, 32'd2);
    write_reg(8'd200, 32'h8000_0000);
    tick(); tick();
    send_beat(16'd30000, 16'h8AD0, 1'b1);
    wait_outs(1);
    got = (outq.size() > 0) ? outq.pop_front() : 'x;
    n_total++; if (got !== {1'b1, 16'h7FFF, 16'h8000})
      $display("FAIL sat_data: got %h want %h", got, {1'b1, 16'h7FFF, 16'h8000}); else n_pass++;
    n_total++; if (clip_count_mag !== 16'd1 || clip_count_phase !== 16'd1)
      $display("FAIL sat_counts: got %0d/%0d want 1/1", clip_count_mag, clip_count_phase); else n_pass++;
    write_reg(8'd200, 32'h0000_0100);
    tick(); tick();
    send_beat(16'd30000, 16'h8AD0, 1'b1);
    wait_outs(1);
    got = (outq.size() > 0) ? outq.pop_front() : 'x;
    n_total++; if (got !== {1'b1, 16'h7FFF, 16'h15A0})
      $display("FAIL wrap_data: got %h want %h", got, {1'b1, 16'h7FFF, 16'h15A0}); else n_pass++;
    n_total++; if (clip_count_mag !== 16'd2 || clip_count_phase !== 16'd1)
      $display("FAIL wrap_counts: got %0d/%0d want 2/1", clip_count_mag, clip_count_phase); else n_pass++;
    write_reg(8'd200, 32'h8000_0100);
    n_total++; if (clip_count_mag !== 16'd0 || clip_count_phase !== 16'd0)
      $display("FAIL clear_counts: got %0d/%0d want 0/0", clip_count_mag, clip_count_phase); else n_pass++;
  endtask

  task automatic test_channels();
    int exp_mag[7] = '{100, 200, 300, 400, 100, 200, 100};
    logic exp_last[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [32:0] got;
    do_reset();
    write_reg(8'd194, 32'd2);
    write_reg(8'd196, 32'd3);
    write_reg(8'd198, 32'd4);
    tick(); tick();
    for (int k = 0; k < 6; k++) send_beat(16'd100, 16'd0, k == 5);
    send_beat(16'd100, 16'd0, 1'b1);
    wait_outs(7);
    for (int k = 0; k < 7; k++) begin
      got = (outq.size() > 0) ? outq.pop_front() : 'x;
      n_total++; if (got !== {exp_last[k], 16'(exp_mag[k]), 16'd0})
        $display("FAIL chan_beat%0d: got %h want %h", k, got, {exp_last[k], 16'(exp_mag[k]), 16'd0});
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int exp_mag[7] = '{100, 100, 100, 100, 300, 100, 500};
    logic exp_last[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [32:0] got;
    do_reset();
    send_beat(16'd100, 16'd0, 1'b0);
    send_beat(16'd100, 16'd0, 1'b0);
    write_reg(8'd192, 32'd3);
    write_reg(8'd196, 32'd5);
    send_beat(16'd100, 16'd0, 1'b0);
    send_beat(16'd100, 16'd0, 1'b1);
    repeat (3) tick();
    send_beat(16'd100, 16'd0, 1'b0);
    send_beat(16'd100, 16'd0, 1'b0);
    send_beat(16'd100, 16'd0, 1'b1);
    wait_outs(7);
    for (int k = 0; k < 7; k++) begin
      got = (outq.size() > 0) ? outq.pop_front() : 'x;
      n_total++; if (got !== {exp_last[k], 16'(exp_mag[k]), 16'd0})
        $display("FAIL shadow_beat%0d: got %h want %h", k, got, {exp_last[k], 16'(exp_mag[k]), 16'd0});
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [32:0] expq[$];
    logic [32:0] got;
    bit prod_done = 0;
    int unsigned left = 0;
    int errs = 0;
    do_reset();
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [31:0] d;
          logic l;
          if (left == 0) left = $urandom_range(1, 7);
          left--;
          l = (left == 0) || (i == 999);
          d = $urandom;
          while ($urandom_range(0, 1) == 0) tick();
          send_beat(d[31:16], d[15:0], l);
          expq.push_back({l, d});
        end
        prod_done = 1;
      end
      begin
        while (!prod_done) begin
          o_tready = $urandom_range(0, 1);
          tick();
        end
        o_tready = 1'b1;
      end
    join
    wait_outs(1000);
    n_total++; if (outq.size() !== 1000) $display("FAIL rand_count: got %0d want 1000", outq.size());
    else n_pass++;
    while (outq.size() > 0 && expq.size() > 0) begin
      got = outq.pop_front();
      if (got !== expq.pop_front()) errs++;
    end
    n_total++; if (errs !== 0) $display("FAIL rand_data: got %0d bad beats want 0", errs); else n_pass++;
    outq.delete();
  endtask

  task automatic test_reset_midpkt();
    logic [32:0] got;
    o_tready = 1'b1;
    write_reg(8'd192, 32'd7);
    tick(); tick();
    send_beat(16'd50, 16'd0, 1'b0);
    send_beat(16'd60, 16'd0, 1'b0);
    tick();
    n_total++; if ({o_tvalid, o_tdata} !== {1'b1, 16'd350, 16'd0})
      $display("FAIL pre_rst_out: got %b_%h want 1_015e0000", o_tvalid, o_tdata); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (o_tvalid !== 1'b0 || o_tdata !== 32'h0)
      $display("FAIL midrst_out: got %b_%h want 0_00000000", o_tvalid, o_tdata); else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    outq.delete();
    send_beat(16'd1234, 16'hFFFB, 1'b1);
    wait_outs(1);
    got = (outq.size() > 0) ? outq.pop_front() : 'x;
    n_total++; if (got !== {1'b1, 16'd1234, 16'hFFFB})
      $display("FAIL post_rst_pass: got %h want %h", got, {1'b1, 16'd1234, 16'hFFFB}); else n_pass++;
    n_total++; if (outq.size() !== 0) $display("FAIL post_rst_extra: got %0d beats want 0", outq.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_gain_shift();
    test_saturate();
    test_channels();
    test_back_to_back();
    test_random();
    test_reset_midpkt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
